maze_sram_arbiter: RTL and testbench

Owns the single-port map SRAM and shares it between a host loader port and the maze router. The host loads the grid (0x00-0x3F) and terminal list (0x80+) and reads back results. On a run request, the block releases the router from reset, pulses its start, and hands it the SRAM. It then waits for done or timeout, reports status, and returns the SRAM to the host.

---
 rtl/maze_sram_arbiter.sv | 152 +++++++++++++++
 tb/tb_maze_sram_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_sram_arbiter.sv
// Map SRAM arbiter: shares the SRAM between the host loader and the maze router.
// Define ARB_STATS_EN to add the last_run_cycles and host_wait outputs.
module maze_sram_arbiter #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_WIDTH      = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_req,
    output logic                  host_gnt,
    input  logic                  host_cs,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    input  logic                  run,
    output logic                  busy,
    output logic                  job_done,
    output logic                  status_fail,
    output logic                  status_timeout,
    output logic [7:0]            job_count,
`ifdef ARB_STATS_EN
    output logic [CNT_WIDTH-1:0]  last_run_cycles,
    output logic                  host_wait,
`endif
    output logic                  rtr_reset,
    output logic                  rtr_start,
    input  logic                  rtr_cs,
    input  logic                  rtr_we,
    input  logic [ADDR_WIDTH-1:0] rtr_addr,
    input  logic [DATA_WIDTH-1:0] rtr_wdata,
    input  logic                  rtr_done,
    input  logic                  rtr_fail,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata
);

    typedef enum logic [2:0] {
        IDLE,
        HOST,
        START,
        RUN,
        FINISH
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TIMER_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state;
    state_t               state_nxt;
    logic                 run_pend;
    logic                 pend_nxt;
    logic [CNT_WIDTH-1:0] timer;
    logic                 time_up;
    logic                 run_end;

    assign time_up = (timer == TIMER_LAST);
    assign run_end = (state == RUN) && (rtr_done || time_up);

    // Host always wins in IDLE; a run seen at any other moment is parked in run_pend.
    always_comb begin
        state_nxt = state;
        pend_nxt  = run_pend | run;
        case (state)
            IDLE: begin
                if (host_req) begin
                    state_nxt = HOST;
                end else if (run || run_pend) begin
                    state_nxt = START;
                    pend_nxt  = 1'b0;
                end
            end
            HOST: begin
                if (!host_req) state_nxt = IDLE;
            end
            START: state_nxt = RUN;
            RUN: begin
                if (rtr_done || time_up) state_nxt = FINISH;
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            run_pend       <= 1'b0;
            timer          <= '0;
            host_gnt       <= 1'b0;
            busy           <= 1'b0;
            job_done       <= 1'b0;
            status_fail    <= 1'b0;
            status_timeout <= 1'b0;
            job_count      <= 8'd0;
            rtr_start      <= 1'b0;
            rtr_reset      <= 1'b1;
        end else begin
            state     <= state_nxt;
            run_pend  <= pend_nxt;
            host_gnt  <= (state_nxt == HOST);
            rtr_start <= (state_nxt == START);
            rtr_reset <= !(state_nxt inside {START, RUN});
            job_done  <= (state_nxt == FINISH);
            busy      <= pend_nxt || (state_nxt inside {START, RUN, FINISH});
            if (state == START) begin
                timer <= '0;
            end else if (state == RUN) begin
                timer <= timer + 1'b1;
            end
            // Done beats a timeout that lands in the same cycle.
            if (run_end) begin
                status_fail    <= rtr_done & rtr_fail;
                status_timeout <= !rtr_done;
                job_count      <= job_count + 8'd1;
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_run_cycles <= '0;
            host_wait       <= 1'b0;
        end else begin
            if (run_end) last_run_cycles <= timer + 1'b1;
            if (host_req && (state inside {START, RUN, FINISH})) host_wait <= 1'b1;
        end
    end
`endif

    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (state == HOST) begin
            sram_cs    = host_cs;
            sram_we    = host_we;
            sram_addr  = host_addr;
            sram_wdata = host_wdata;
        end else if (state == START || state == RUN) begin
            sram_cs    = rtr_cs;
            sram_we    = rtr_we;
            sram_addr  = rtr_addr;
            sram_wdata = rtr_wdata;
        end
    end

endmodule

// File: tb/tb_maze_sram_arbiter.sv
// Self-checking bench for maze_sram_arbiter with a job-level reference model
// (expected outcome and latency derived from router delay vs. timeout).
module tb_maze_sram_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int T  = 16;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic host_req = 0, host_cs = 0, host_we = 0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic run = 0;
    logic rtr_cs = 0, rtr_we = 0, rtr_done = 0, rtr_fail = 0;
    logic [AW-1:0] rtr_addr = '0;
    logic [DW-1:0] rtr_wdata = '0;
    logic host_gnt, busy, job_done, status_fail, status_timeout;
    logic [7:0] job_count;
    logic rtr_reset, rtr_start, sram_cs, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
`ifdef ARB_STATS_EN
    logic [CW-1:0] last_run_cycles;
    logic host_wait;
`endif

    int errors = 0;
    int checks = 0;
    int count_m = 0;
    bit pend_m = 0;
    bit hw_m = 0;

    maze_sram_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(T), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .host_req(host_req), .host_gnt(host_gnt),
        .host_cs(host_cs), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .run(run), .busy(busy), .job_done(job_done),
        .status_fail(status_fail), .status_timeout(status_timeout),
        .job_count(job_count),
`ifdef ARB_STATS_EN
        .last_run_cycles(last_run_cycles), .host_wait(host_wait),
`endif
        .rtr_reset(rtr_reset), .rtr_start(rtr_start),
        .rtr_cs(rtr_cs), .rtr_we(rtr_we),
        .rtr_addr(rtr_addr), .rtr_wdata(rtr_wdata),
        .rtr_done(rtr_done), .rtr_fail(rtr_fail),
        .sram_cs(sram_cs), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        count_m = 0; pend_m = 0; hw_m = 0;
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", host_gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (job_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", job_done); end
        checks++; if ({status_fail, status_timeout} !== 2'b00) begin errors++; $display("FAIL reset_status: got %b%b want 00", status_fail, status_timeout); end
        checks++; if (job_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", job_count); end
        checks++; if ({rtr_reset, rtr_start} !== 2'b10) begin errors++; $display("FAIL reset_rtr: got %b%b want 10", rtr_reset, rtr_start); end
        checks++; if (sram_cs !== 1'b0) begin errors++; $display("FAIL reset_sram_cs: got %b want 0", sram_cs); end
`ifdef ARB_STATS_EN
        checks++; if ({last_run_cycles, host_wait} !== '0) begin errors++; $display("FAIL reset_stats: got %0d/%b want 0/0", last_run_cycles, host_wait); end
`endif
    endtask

    task automatic test_host;
        logic [AW+DW+1:0] want;
        host_req = 1'b1;
        rtr_cs = 1'b1; rtr_we = 1'b1; rtr_addr = 8'h77; rtr_wdata = 8'h55;
        tick;
        checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL host_gnt: got %b want 1", host_gnt); end
        checks++; if (rtr_reset !== 1'b1) begin errors++; $display("FAIL host_rtr_reset: got %b want 1", rtr_reset); end
        host_cs = 1'b1; host_we = 1'b1; host_addr = 8'h05; host_wdata = 8'hAB;
        #1;
        checks++; if ({sram_cs, sram_we, sram_addr, sram_wdata} !== {2'b11, 8'h05, 8'hAB}) begin errors++; $display("FAIL host_write: got %b%b %h %h want 11 05 ab", sram_cs, sram_we, sram_addr, sram_wdata); end
        tick;
        host_we = 1'b0; host_wdata = 8'h00;
        #1;
        checks++; if ({sram_cs, sram_we, sram_addr} !== {2'b10, 8'h05}) begin errors++; $display("FAIL host_read: got %b%b %h want 10 05", sram_cs, sram_we, sram_addr); end
        for (int i = 0; i < 8; i++) begin
            tick;
            host_cs = 1'($urandom); host_we = 1'($urandom);
            host_addr = AW'($urandom); host_wdata = DW'($urandom);
            rtr_cs = 1'($urandom); rtr_we = 1'($urandom);
            rtr_addr = AW'($urandom); rtr_wdata = DW'($urandom);
            want = {host_cs, host_we, host_addr, host_wdata};
            #1;
            checks++; if ({sram_cs, sram_we, sram_addr, sram_wdata} !== want) begin errors++; $display("FAIL host_mux: got %h want %h", {sram_cs, sram_we, sram_addr, sram_wdata}, want); end
            checks++; if ({host_gnt, rtr_reset} !== 2'b11) begin errors++; $display("FAIL host_hold: got %b want 11", {host_gnt, rtr_reset}); end
        end
        host_cs = 1'b1;
        host_req = 1'b0;
        tick;
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL host_release: got %b want 0", host_gnt); end
        checks++; if (sram_cs !== 1'b0) begin errors++; $display("FAIL idle_sram_cs: got %b want 0", sram_cs); end
        host_cs = 1'b0; host_we = 1'b0;
        rtr_cs = 1'b0; rtr_we = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        bit seen = 0;
        run = 1'b1;
        tick;
        run = 1'b0;
        checks++; if (rtr_start !== 1'b1) begin errors++; $display("FAIL mid_start: got %b want 1", rtr_start); end
        tick; tick; tick;
        checks++; if (rtr_reset !== 1'b0) begin errors++; $display("FAIL mid_rtr_run: got %b want 0", rtr_reset); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        count_m = 0; pend_m = 0; hw_m = 0;
        checks++; if ({rtr_reset, busy, job_done} !== 3'b100) begin errors++; $display("FAIL mid_reset: got %b want 100", {rtr_reset, busy, job_done}); end
        for (int i = 0; i < 6; i++) begin
            if (job_done) seen = 1;
            tick;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_done: got %b want 0", seen); end
        checks++; if (job_count !== 8'(count_m)) begin errors++; $display("FAIL mid_count: got %0d want %0d", job_count, count_m); end
    endtask

    task automatic start_job;
        run = 1'b1;
        tick;
        run = 1'b0;
    endtask

    // Entered with the DUT in START; router finishes in RUN cycle d.
    task automatic do_job(input int d, input bit f, input bit hreq, input int nrun);
        int n = 0, starts = 0, extra = 0, exp_n;
        bit ok_mux = 1, ok_rst = 1, ok_gnt = 1, ok_busy = 1;
        bit exp_f, exp_to;
        exp_n  = (d <= T) ? d + 2 : T + 2;
        exp_f  = (d <= T) ? f : 1'b0;
        exp_to = (d > T);
        host_req = hreq;
        if (hreq) hw_m = 1;
        for (int c = 1; c <= T + 8 && n == 0; c++) begin
            if (job_done) begin
                n = c;
            end else begin
                if (rtr_start) starts++;
                if (rtr_reset !== 1'b0) ok_rst = 0;
                if (host_gnt !== 1'b0) ok_gnt = 0;
                if (busy !== 1'b1) ok_busy = 0;
                rtr_cs = 1'($urandom); rtr_we = 1'($urandom);
                rtr_addr = AW'($urandom); rtr_wdata = DW'($urandom);
                rtr_done = (c == d + 1);
                rtr_fail = (c == d + 1) ? f : 1'($urandom);
                run = (c >= 3) && (c % 2 == 1) && (extra < nrun);
                if (run) extra++;
                #1;
                if ({sram_cs, sram_we, sram_addr, sram_wdata} !== {rtr_cs, rtr_we, rtr_addr, rtr_wdata}) ok_mux = 0;
                tick;
            end
        end
        run = 1'b0; rtr_done = 1'b0; rtr_fail = 1'b0;
        rtr_cs = 1'b0; rtr_we = 1'b0;
        if (extra > 0) pend_m = 1;
        count_m = (count_m + 1) % 256;
        checks++; if (n !== exp_n) begin errors++; $display("FAIL job_latency d=%0d: got %0d want %0d", d, n, exp_n); end
        checks++; if (starts !== 1) begin errors++; $display("FAIL job_start_len: got %0d want 1", starts); end
        checks++; if ({ok_mux, ok_rst, ok_gnt, ok_busy} !== 4'hF) begin errors++; $display("FAIL job_run_signals: got %b want 1111", {ok_mux, ok_rst, ok_gnt, ok_busy}); end
        checks++; if ({status_fail, status_timeout} !== {exp_f, exp_to}) begin errors++; $display("FAIL job_status d=%0d: got %b%b want %b%b", d, status_fail, status_timeout, exp_f, exp_to); end
        checks++; if (job_count !== 8'(count_m)) begin errors++; $display("FAIL job_count: got %0d want %0d", job_count, count_m); end
        checks++; if ({sram_cs, rtr_reset, rtr_start, busy} !== 4'b0101) begin errors++; $display("FAIL job_finish: got %b want 0101", {sram_cs, rtr_reset, rtr_start, busy}); end
`ifdef ARB_STATS_EN
        checks++; if (last_run_cycles !== CW'((d <= T) ? d : T)) begin errors++; $display("FAIL job_cycles: got %0d want %0d", last_run_cycles, (d <= T) ? d : T); end
        checks++; if (host_wait !== hw_m) begin errors++; $display("FAIL job_host_wait: got %b want %b", host_wait, hw_m); end
`endif
        tick;
        checks++; if ({job_done, rtr_reset, host_gnt, sram_cs} !== 4'b0100) begin errors++; $display("FAIL job_after: got %b want 0100", {job_done, rtr_reset, host_gnt, sram_cs}); end
        checks++; if (busy !== pend_m) begin errors++; $display("FAIL job_after_busy: got %b want %b", busy, pend_m); end
    endtask

    task automatic test_normal;
        start_job; do_job(12, 1'b0, 1'b0, 0);
    endtask

    task automatic test_router_fail;
        start_job; do_job(7, 1'b1, 1'b0, 0);
    endtask

    task automatic test_timeout;
        start_job; do_job(T + 5, 1'b1, 1'b0, 0);
        start_job; do_job(T, 1'b1, 1'b0, 0);
        start_job; do_job(T + 1, 1'b0, 1'b0, 0);
        tick;
        checks++; if (sram_cs !== 1'b0) begin errors++; $display("FAIL timeout_idle_cs: got %b want 0", sram_cs); end
    endtask

    task automatic test_contention;
        host_req = 1'b1; run = 1'b1;
        tick;
        run = 1'b0;
        checks++; if ({host_gnt, busy, rtr_start} !== 3'b110) begin errors++; $display("FAIL cont_grant: got %b want 110", {host_gnt, busy, rtr_start}); end
        tick; tick;
        checks++; if ({host_gnt, busy} !== 2'b11) begin errors++; $display("FAIL cont_hold: got %b want 11", {host_gnt, busy}); end
        host_req = 1'b0;
        tick;
        checks++; if ({host_gnt, busy, rtr_start} !== 3'b010) begin errors++; $display("FAIL cont_release: got %b want 010", {host_gnt, busy, rtr_start}); end
        tick;
        checks++; if (rtr_start !== 1'b1) begin errors++; $display("FAIL cont_pend_start: got %b want 1", rtr_start); end
        pend_m = 0;
        do_job(10, 1'b0, 1'b0, 2);
        tick;
        checks++; if (rtr_start !== 1'b1) begin errors++; $display("FAIL cont_extra_start: got %b want 1", rtr_start); end
        pend_m = 0;
        do_job(5, 1'b0, 1'b0, 0);
        tick;
        checks++; if ({rtr_start, busy} !== 2'b00) begin errors++; $display("FAIL cont_one_extra: got %b want 00", {rtr_start, busy}); end
    endtask

    task automatic test_host_during_job;
        start_job;
        do_job(8, 1'b0, 1'b1, 0);
        tick;
        checks++; if ({host_gnt, busy, rtr_reset} !== 3'b101) begin errors++; $display("FAIL wait_grant: got %b want 101", {host_gnt, busy, rtr_reset}); end
        host_req = 1'b0;
        tick;
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL wait_release: got %b want 0", host_gnt); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 20; i++) begin
            start_job;
            do_job(int'($urandom_range(1, T + 4)), 1'($urandom), 1'b0, 0);
        end
    endtask

    task automatic test_wrap;
        while (count_m != 255) begin
            start_job;
            do_job(1, 1'b0, 1'b0, 0);
        end
        start_job;
        do_job(2, 1'b1, 1'b0, 0);
        checks++; if (job_count !== 8'd0) begin errors++; $display("FAIL wrap_count: got %0d want 0", job_count); end
    endtask

    initial begin
        test_reset;
        test_host;
        test_reset_mid_run;
        test_normal;
        test_router_fail;
        test_timeout;
        test_contention;
        test_host_during_job;
        test_random;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
